// File: rtl/mem_arbiter.sv
// Shares one backend memory port between the fetch and data requesters.
// Data requests have priority over fetches. A stuck access is force-completed with an error.
module mem_arbiter #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  // state | meaning
  // IDLE  | no backend access; choose the next requester
  // D_ACC | data access in flight on the backend
  // I_ACC | fetch access in flight on the backend
  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        done_d, done_i;
  logic [7:0]  wait_cnt;
  logic        in_acc, timeout, complete;

  assign stall    = (d_req & ~done_d) | (if_req & ~done_i);
  assign in_acc   = (state != IDLE);
  // A coincident ack beats the timeout.
  assign timeout  = in_acc & ~mem_ack & (wait_cnt == WAIT_LAST);
  assign complete = in_acc & (mem_ack | timeout);

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (state)
      IDLE: begin
        if (d_req && !done_d)       state_nxt = D_ACC;
        else if (if_req && !done_i) state_nxt = I_ACC;
      end
      D_ACC: begin
        mem_req   = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        if (complete) state_nxt = IDLE;
      end
      I_ACC: begin
        mem_req  = 1'b1;
        mem_addr = if_addr;
        if (complete) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      done_d   <= 1'b0;
      done_i   <= 1'b0;
      wait_cnt <= 8'd0;
      if_rdata <= 32'h0;
      d_rdata  <= 32'h0;
      bus_err  <= 1'b0;
      err_addr <= 32'h0;
    end else begin
      state <= state_nxt;

      if (!stall) begin
        done_d <= 1'b0;
        done_i <= 1'b0;
      end

      if (!in_acc)       wait_cnt <= 8'd0;
      else if (!mem_ack) wait_cnt <= wait_cnt + 8'd1;

      // Completion sets its flag even when the request already dropped.
      if (state == D_ACC && complete) begin
        done_d <= 1'b1;
        if (d_we == 4'b0000) d_rdata <= mem_ack ? mem_rdata : ERR_DATA;
      end
      if (state == I_ACC && complete) begin
        done_i   <= 1'b1;
        if_rdata <= mem_ack ? mem_rdata : ERR_DATA;
      end

      if (timeout) begin
        bus_err <= 1'b1;
        if (!bus_err) err_addr <= mem_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven pipeline steps, a backend
// responder with programmable ack delay, and a queue of expected backend accesses.
module tb_mem_arbiter;

  localparam logic [31:0] KEY = 32'h8C48_0004;

  logic        clk, rst_n;
  logic        if_req, d_req;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_we;
  logic [31:0] if_rdata, d_rdata;
  logic        stall, mem_req, mem_ack, bus_err;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, err_addr;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err), .err_addr(err_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        i_req;
    logic [31:0] i_addr;
    int          delay;
    int          exp_stall;
    logic [31:0] exp_d;
    logic [31:0] exp_i;
    logic        exp_be;
    logic [31:0] exp_ea;
  } vec_t;

  acc_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ack_delay = 0;
  int   wcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Backend responder: acks after ack_delay wait cycles; checks each access on its first cycle.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wcnt == 0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_access: got addr 0x%08h expected no access", mem_addr);
        end else begin
          acc_t t;
          t = exp_q.pop_front();
          chk("mem_we", {28'h0, mem_we}, {28'h0, t.we});
          chk("mem_addr", mem_addr, t.addr);
          chk("mem_wdata", mem_wdata, t.wdata);
        end
      end
      if (wcnt == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr ^ KEY;
      end else begin
        mem_ack = 1'b0;
      end
      wcnt++;
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  task automatic run_step(input vec_t v);
    int cyc;
    bit done;
    @(posedge clk); #1;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    if_req = v.i_req; if_addr = v.i_addr; ack_delay = v.delay;
    if (v.d_req) exp_q.push_back('{v.d_we, v.d_addr, v.d_wdata});
    if (v.i_req) exp_q.push_back('{4'b0000, v.i_addr, 32'h0});
    cyc  = 0;
    done = 1'b0;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (stall) cyc++;
      else done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL stall_release: got stall stuck high expected release within 1000 cycles");
    end
    chk("stall_cycles", cyc, v.exp_stall);
    chk("d_rdata", d_rdata, v.exp_d);
    chk("if_rdata", if_rdata, v.exp_i);
    chk("bus_err", {31'h0, bus_err}, {31'h0, v.exp_be});
    chk("err_addr", err_addr, v.exp_ea);
    chk("backend_queue_empty", exp_q.size(), 0);
  endtask

  vec_t vecs[9];

  initial begin
    int  cnt;
    bit  seen, ended;

    vecs[0] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0040_0000, 1,   3,   32'h0000_0000, 32'h8C08_0004, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 4'h0, 32'h1001_0000, 32'h0, 1'b1, 32'h0040_0004, 0, 4, 32'h9C49_0004, 32'h8C08_0000, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 4'hC, 32'h2000_0008, 32'hABCD_0000, 1'b0, 32'h0, 0, 2, 32'h9C49_0004, 32'h8C08_0000, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 4'h1, 32'h2000_0003, 32'h0000_00EF, 1'b1, 32'h0040_0008, 2, 8, 32'h9C49_0004, 32'h8C08_000C, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 4'h0, 32'h3000_0010, 32'h0, 1'b0, 32'h0, 5, 7, 32'hBC48_0014, 32'h8C08_000C, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 4'h0, 32'h1234_5678, 32'h0, 1'b0, 32'h0, 254, 256, 32'h9E7C_567C, 32'h8C08_000C, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 4'h0, 32'hFFFF_0000, 32'h0, 1'b0, 32'h0, 300, 256, 32'hDEAD_BEEF, 32'h8C08_000C, 1'b1, 32'hFFFF_0000};
    vecs[7] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0040_0100, 300, 256, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'hFFFF_0000};
    vecs[8] = '{1'b1, 4'h0, 32'h0000_0040, 32'h0, 1'b1, 32'h0040_000C, 1, 6, 32'h8C48_0044, 32'h8C08_0008, 1'b1, 32'hFFFF_0000};

    rst_n = 1'b1;
    if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mem_req", {31'h0, mem_req}, 32'h0);
    chk("reset_mem_we", {28'h0, mem_we}, 32'h0);
    chk("reset_d_rdata", d_rdata, 32'h0);
    chk("reset_if_rdata", if_rdata, 32'h0);
    chk("reset_bus_err", {31'h0, bus_err}, 32'h0);
    chk("reset_err_addr", err_addr, 32'h0);
    chk("reset_stall", {31'h0, stall}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_step(vecs[i]);

    // Data request drops while its access is still waiting for ack.
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b1; d_we = 4'h0; d_addr = 32'h4000_0020; ack_delay = 3;
    exp_q.push_back('{4'h0, 32'h4000_0020, 32'h0});
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    chk("drop_access_started", {31'h0, seen}, 32'h1);
    @(posedge clk); #1 d_req = 1'b0;
    cnt   = 1;
    ended = 1'b0;
    for (int k = 0; k < 20 && !ended; k++) begin
      @(negedge clk);
      if (mem_req) cnt++;
      else ended = 1'b1;
    end
    chk("drop_acc_cycles", cnt, 4);
    chk("drop_d_rdata", d_rdata, 32'hCC48_0024);
    run_step('{1'b1, 4'h0, 32'h4000_0024, 32'h0, 1'b0, 32'h0, 0, 2,
               32'hCC48_0020, 32'h8C08_0008, 1'b1, 32'hFFFF_0000});

    // Reset asserted mid-access, between clock edges.
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h5000_0000; ack_delay = 300;
    exp_q.push_back('{4'h0, 32'h5000_0000, 32'h0});
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    chk("rst_access_started", {31'h0, seen}, 32'h1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mid_mem_we", {28'h0, mem_we}, 32'h0);
    chk("rst_mid_mem_addr", mem_addr, 32'h0);
    chk("rst_mid_d_rdata", d_rdata, 32'h0);
    chk("rst_mid_if_rdata", if_rdata, 32'h0);
    chk("rst_mid_bus_err", {31'h0, bus_err}, 32'h0);
    chk("rst_mid_err_addr", err_addr, 32'h0);
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_step('{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0040_0010, 0, 2,
               32'h0000_0000, 32'h8C08_0014, 1'b0, 32'h0});

    @(posedge clk); #1;
    d_req = 1'b0; if_req = 1'b0;
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: cycles without mem_ack before an access is force-completed with an error; legal range 1-255.
REQ-002 Parameter ERR_DATA, default 32'hDEADBEEF: read data returned on a timed-out read.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 if_req  in  1  instruction fetch request, level, held while stall=1.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_rdata  out  32  registered fetch data.
REQ-008 d_req  in  1  data request from MEM stage, level, held while stall=1.
REQ-009 d_we  in  4  byte write enables; 4'b0000 = read.
REQ-010 d_addr  in  32  data byte address.
REQ-011 d_wdata  in  32  lane-aligned write data.
REQ-012 d_rdata  out  32  registered data-read result.
REQ-013 stall  out  1  pipeline freeze, combinational.
REQ-014 mem_req  out  1  backend access strobe.
REQ-015 mem_we  out  4  backend byte enables.
REQ-016 mem_addr  out  32  backend address.
REQ-017 mem_wdata  out  32  backend write data.
REQ-018 mem_rdata  in  32  backend read data, valid with mem_ack.
REQ-019 mem_ack  in  1  backend completion, may assert in the same cycle mem_req rises.
REQ-020 bus_err  out  1  sticky timeout flag.
REQ-021 err_addr  out  32  address of the first timed-out access.

Function
REQ-022 States: IDLE, D_ACC, I_ACC; one backend access in flight at a time.
REQ-023 Flags done_d, done_i record completion of the current pipeline step's data and fetch requests.
REQ-024 stall = (d_req & !done_d) | (if_req & !done_i), evaluated combinationally in every state.
REQ-025 Any posedge with stall=0 clears done_d and done_i, so the pipeline advances and new requests are served.
REQ-026 IDLE: d_req & !done_d -> D_ACC; else if_req & !done_i -> I_ACC; else remain in IDLE. Data has fixed priority over fetch.
REQ-027 In IDLE, mem_req=0, mem_we=0, and mem_addr/mem_wdata=0.
REQ-028 In D_ACC, mem_req=1, mem_we=d_we, mem_addr=d_addr, and mem_wdata=d_wdata.
REQ-029 In I_ACC, mem_req=1, mem_we=0, mem_addr=if_addr, and mem_wdata=0.
REQ-030 On mem_ack in D_ACC: set done_d; if d_we==0, d_rdata<=mem_rdata; return to IDLE.
REQ-031 On mem_ack in I_ACC: set done_i; if_rdata<=mem_rdata; return to IDLE.
REQ-032 d_rdata and if_rdata hold their values until the next capture and are never cleared by a stall release.
REQ-033 Latency: an access entered from IDLE at cycle N has mem_req high at N+1; with ack at N+1, stall drops at N+2. The minimum cost is 2 cycles per access and 4 cycles when both requests are present.
REQ-034 A 8-bit wait counter clears on ACC entry and increments each ACC cycle without mem_ack.
REQ-035 When the wait counter reaches TIMEOUT_CYCLES-1 without mem_ack, the access completes as if acked with mem_rdata=ERR_DATA (reads only) and bus_err<=1.
REQ-036 err_addr captures mem_addr only when bus_err was 0 before that timeout.
REQ-037 If the requester drops its request while in ACC, the access still runs to ack or timeout, and mem_req is never deasserted early.
REQ-038 A result that completes after its request has dropped is still captured; its done flag is cleared at the next stall=0 edge.
REQ-039 If mem_ack and timeout coincide, mem_ack wins, no error is flagged, and mem_rdata is used.
REQ-040 Writes with d_we!=0 at any byte lane are forwarded unchanged; the arbiter performs no alignment checks.
REQ-041 mem_ack sampled in IDLE is ignored.

Reset
REQ-042 rst_n=0 asynchronously forces state IDLE, done_d=done_i=0, wait counter=0, if_rdata=d_rdata=0, bus_err=0, and err_addr=0.
REQ-043 During reset, mem_req=0 and mem_we=0 immediately, without waiting for a clock edge.
REQ-044 Reset asserted mid-access abandons the access; the backend must tolerate mem_req dropping without ack.
REQ-045 The first access after reset deassertion starts no earlier than the first posedge with rst_n=1.

Verification
REQ-046 Fetch only: if_req=1, if_addr=0x00400000, ack with 0x8C080004 one cycle after mem_req -> stall high 3 cycles, then if_rdata=0x8C080004.
REQ-047 Both requests: d_req=1 read at 0x10010000, if_req=1, instant acks -> mem_addr sequence 0x10010000 then 0x00400004, and stall drops only after both complete.
REQ-048 Store: d_we=4'b1100, d_wdata=0xABCD0000 -> mem_we=4'b1100, mem_wdata=0xABCD0000, and d_rdata unchanged.
REQ-049 Timeout: mem_ack tied low, data read at 0xFFFF0000 -> after 255 ACC cycles d_rdata=0xDEADBEEF, bus_err=1, err_addr=0xFFFF0000, and stall released.
REQ-050 Reset mid-access: assert rst_n=0 during D_ACC -> mem_req=0 with no clock edge, and all outputs take their reset values.
REQ-051 Ack/timeout collision: mem_ack first asserts on the cycle where the wait counter reaches TIMEOUT_CYCLES-1 -> bus_err stays 0 and mem_rdata is captured.
